// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl
//   Text-terminal cursor engine. It sits between the UART receiver and the
//   character-buffer RAM. Printable bytes become RAM writes at the cursor.
//   CR, LF, BS and FF move the cursor or clear the screen. At the bottom row
//   the screen either scrolls or wraps the cursor to logical row 0. Scrolling
//   rotates a top-row pointer, which the VGA read side adds to its row address.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   rx_data, rx_valid  received byte and its single-cycle strobe
//   wr_en/row/col/data character RAM write port (physical row)
//   cursor_row/col     logical cursor position
//   top_row            physical row displayed on screen line 0
//   busy               a clear sequence is in progress
//   overrun            sticky flag: a byte was dropped

module text_cursor_ctrl #(
  parameter int          COLS      = 32,
  parameter int          ROWS      = 4,
  parameter int          COL_W     = 5,
  parameter int          ROW_W     = 2,
  parameter int          SCROLL    = 1,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] top_row,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W:0]   COLS_CNT = (COL_W + 1)'(COLS);
  localparam logic [ROW_W:0]   ROWS_CNT = (ROW_W + 1)'(ROWS);

  state_t           state;
  logic             pend_vld;
  logic [7:0]       pend_data;
  logic [ROW_W-1:0] clr_prow;   // physical row being cleared in CLR_ROW
  logic [COL_W:0]   clr_cnt;    // next column to clear
  logic [ROW_W:0]   clr_r;      // next row to clear in CLR_ALL

  logic             take;
  logic [7:0]       cur_byte;
  logic             is_print;
  logic             is_lf;
  logic             do_nl;
  logic [ROW_W-1:0] cur_prow;
  logic [ROW_W-1:0] top_next;

  // The sum is at most 2*ROWS-2, so one conditional subtract is enough.
  // ROWS does not have to be a power of two.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] top,
                                                input logic [ROW_W-1:0] r);
    logic [ROW_W:0] s;
    s = {1'b0, top} + {1'b0, r};
    if (s >= ROWS_CNT) s = s - ROWS_CNT;
    return s[ROW_W-1:0];
  endfunction

  // A byte waiting in the pending slot takes priority over a new arrival.
  // That keeps bytes in order when the slot is refilled in the same cycle.
  always_comb begin
    take     = (state == IDLE) && (pend_vld || rx_valid);
    cur_byte = pend_vld ? pend_data : rx_data;
    is_print = (cur_byte >= 8'h20) && (cur_byte <= 8'h7E);
    is_lf    = (cur_byte == 8'h0A);
    do_nl    = take && (is_lf || (is_print && (cursor_col == COL_LAST)));
    cur_prow = phys_row(top_row, cursor_row);
    top_next = (top_row == ROW_LAST) ? '0 : top_row + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend_vld   <= 1'b0;
      pend_data  <= '0;
      clr_prow   <= '0;
      clr_cnt    <= '0;
      clr_r      <= '0;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      top_row    <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_en <= 1'b0;

      // Pending slot: it fills while busy. It is consumed on the first idle
      // cycle and can be refilled in that same cycle.
      if (busy) begin
        if (rx_valid) begin
          if (pend_vld) begin
            overrun <= 1'b1;
          end else begin
            pend_vld  <= 1'b1;
            pend_data <= rx_data;
          end
        end
      end else if (pend_vld) begin
        pend_vld <= rx_valid;
        if (rx_valid) pend_data <= rx_data;
      end

      case (state)
        IDLE: begin
          if (take) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_row  <= cur_prow;
              wr_col  <= cursor_col;
              wr_data <= cur_byte;
              if (cursor_col != COL_LAST) cursor_col <= cursor_col + 1'b1;
            end else if (cur_byte == 8'h0D) begin
              cursor_col <= '0;
            end else if (cur_byte == 8'h08) begin
              if (cursor_col != '0) begin
                cursor_col <= cursor_col - 1'b1;
                wr_en      <= 1'b1;
                wr_row     <= cur_prow;
                wr_col     <= cursor_col - 1'b1;
                wr_data    <= FILL_CHAR;
              end
            end else if (cur_byte == 8'h0C) begin
              // The first fill write goes out now. The rest follow in CLR_ALL.
              state   <= CLR_ALL;
              busy    <= 1'b1;
              wr_en   <= 1'b1;
              wr_row  <= '0;
              wr_col  <= '0;
              wr_data <= FILL_CHAR;
              clr_cnt <= (COL_W + 1)'(1);
              clr_r   <= '0;
            end

            if (do_nl) begin
              cursor_col <= '0;
              if (cursor_row != ROW_LAST) begin
                cursor_row <= cursor_row + 1'b1;
              end else if (SCROLL == 0) begin
                cursor_row <= '0;
              end else begin
                // After the rotation, the old top row is the new bottom line.
                top_row  <= top_next;
                state    <= CLR_ROW;
                busy     <= 1'b1;
                clr_prow <= top_row;
                if (is_lf) begin
                  // The write port is free, so clearing starts immediately.
                  wr_en   <= 1'b1;
                  wr_row  <= top_row;
                  wr_col  <= '0;
                  wr_data <= FILL_CHAR;
                  clr_cnt <= (COL_W + 1)'(1);
                end else begin
                  // The character write uses the port this cycle.
                  clr_cnt <= '0;
                end
              end
            end
          end
        end

        CLR_ROW: begin
          if (clr_cnt == COLS_CNT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_row  <= clr_prow;
            wr_col  <= clr_cnt[COL_W-1:0];
            wr_data <= FILL_CHAR;
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        CLR_ALL: begin
          if (clr_r == ROWS_CNT) begin
            state      <= IDLE;
            busy       <= 1'b0;
            top_row    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
          end else begin
            wr_en   <= 1'b1;
            wr_row  <= clr_r[ROW_W-1:0];
            wr_col  <= clr_cnt[COL_W-1:0];
            wr_data <= FILL_CHAR;
            if (clr_cnt == COLS_CNT - 1'b1) begin
              clr_cnt <= '0;
              clr_r   <= clr_r + 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/text_cursor_ctrl.md
Name: text_cursor_ctrl

Overview:
Parametrised text-terminal cursor engine between the UART receiver and the character-buffer dual-port RAM. It consumes received bytes, turns printable characters into RAM writes at the cursor, and interprets CR, LF, BS and FF. It supports wrap or hardware scroll; scroll uses a rotating top-row pointer that the VGA read side adds to its row address. It replaces the ad-hoc cursor logic in the top level.

Parameters:
COLS, 32, characters per row (>=2)
ROWS, 4, text rows (>=2)
COL_W, 5, column index width (>= clog2(COLS))
ROW_W, 2, row index width (>= clog2(ROWS))
SCROLL, 1, 1 = scroll at bottom, 0 = wrap cursor to logical row 0
FILL_CHAR, 8'h20, byte written by all clear operations

Ports:
clk  in  1  system clock (100 MHz)
reset_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid only with rx_valid
rx_valid  in  1  single-cycle strobe, one byte (already pulse-shaped upstream)
wr_en  out  1  RAM write strobe, one cycle per write
wr_row  out  ROW_W  physical RAM row for the write
wr_col  out  COL_W  RAM column for the write
wr_data  out  8  byte to write
cursor_row  out  ROW_W  logical (screen-relative) cursor row
cursor_col  out  COL_W  cursor column
top_row  out  ROW_W  physical row shown at screen line 0
busy  out  1  high while a clear sequence runs
overrun  out  1  sticky: a byte was dropped

Behaviour:
- Async reset (reset_n=0): state IDLE; all outputs 0; pending slot empty; overrun 0.
- Physical row = (top_row + cursor_row) mod ROWS. Use explicit compare-and-subtract; ROWS need not be a power of two.
- All outputs registered. A byte accepted in cycle N produces its wr_en and its updated cursor in cycle N+1.
- States: IDLE, CLR_ROW, CLR_ALL.
- IDLE byte decode:
  - 0x20..0x7E: write the byte at the cursor, then advance.
  - 0x0D (CR): cursor_col=0, no write.
  - 0x0A (LF): newline, no write.
  - 0x08 (BS): if cursor_col>0, decrement it and write FILL_CHAR at the new position; at col 0, no action.
  - 0x0C (FF): go to CLR_ALL.
  - Any other byte: ignored.
- Advance: cursor_col+1. If cursor_col==COLS-1, do a newline instead.
- Newline, cursor_row<ROWS-1: cursor_col=0, cursor_row+1.
- Newline, cursor_row==ROWS-1, SCROLL=0: cursor_col=0, cursor_row=0, no clear.
- Newline, cursor_row==ROWS-1, SCROLL=1:
  - top_row=(top_row+1) mod ROWS; cursor stays at logical ROWS-1, col 0.
  - Enter CLR_ROW to clear the physical row now at the bottom, i.e. the old top_row.
  - For a printable char at the last column, the char write occurs in the same cycle as the scroll update; CLR_ROW starts the next cycle.
- CLR_ROW: COLS consecutive cycles, wr_en=1, wr_col 0..COLS-1, wr_data=FILL_CHAR, busy=1. Return to IDLE after column COLS-1.
- CLR_ALL: ROWS*COLS consecutive writes, row-major from physical (0,0), busy=1. On completion: top_row=0, cursor (0,0), IDLE.
- busy rises in the cycle after the triggering byte and falls in the cycle after the last clear write.
- Pending slot (1 entry):
  - rx_valid while busy latches the byte into the slot.
  - rx_valid while busy with the slot full drops the byte and sets overrun. overrun clears only on reset.
  - On the first IDLE cycle the pending byte is processed as if it had just arrived; the slot frees that cycle.
  - rx_valid in that same cycle: the new byte goes into the freed slot and is processed the following cycle. No loss.
- Reset mid-clear aborts immediately to reset values; no further writes.
- wr_row/wr_col/wr_data hold their last values when wr_en=0.

Test Plan:
- Reset, send 'A','B' (0x41,0x42) -> wr_en pulses with (row0,col0,0x41) then (row0,col1,0x42), each 1 cycle after rx_valid; cursor_col=2.
- Send 32 printable chars with COLS=32 -> 32nd write at col31, then cursor (1,0), top_row 0; CR at col5 -> col0, no write.
- SCROLL=1: fill to logical row 3, send LF -> top_row 1; 32 writes of 0x20 to physical row 0, busy high exactly 32 cycles; cursor (3,0).
- SCROLL=0, same stimulus -> cursor (0,0), top_row 0, no clear writes, busy stays 0.
- BS at col3 -> write 0x20 at col2, cursor_col 2; BS at col0 -> no write, cursor unchanged.
- FF then two bytes during CLR_ALL -> 128 fill writes; first byte held and written at (0,0) right after busy falls; second byte dropped, overrun=1. Repeat with reset_n low mid-clear -> writes stop, all outputs 0.
